// File: rtl/mmio_uart_tx_if.sv
// Store/load snoop bus between the core's memory stage and the MMIO UART transmitter.
interface mmio_uart_tx_if;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic [31:0] rdata;

    modport master (output MemWriteM, DataAdrM, WriteDataM, input rdata);
    modport slave  (input MemWriteM, DataAdrM, WriteDataM, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA feed a small FIFO that is
// serialised LSB first on tx; STATUS is returned combinationally on the load path.
module mmio_uart_tx #(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00
) (
    input  logic         clk,
    input  logic         reset,
    mmio_uart_tx_if.slave bus,
    output logic         tx,
    output logic         busy,
    output logic         fifo_full
);

    localparam int CNT_W   = $clog2(CLK_DIV);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]   LAST_TICK  = CNT_W'(CLK_DIV - 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             r_state, w_nextState;
    logic [CNT_W-1:0]   r_bitCnt, w_bitCntNext;
    logic [2:0]         r_bitIdx, w_bitIdxNext;
    logic [7:0]         r_shift, w_shiftNext;
    logic               r_tx, w_txNext;
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr, r_rdPtr;
    logic [COUNT_W-1:0] r_count;
    logic               r_overflow;

    logic       w_bitEnd, w_notEmpty, w_pop, w_pushReq, w_push, w_drop, w_clr;
    logic [3:0] w_status;
    logic       w_unused;

    assign w_bitEnd   = (r_bitCnt == LAST_TICK);
    assign w_notEmpty = (r_count != '0);
    assign w_pushReq  = bus.MemWriteM && (bus.DataAdrM == BASE_ADDR);
    assign w_clr      = bus.MemWriteM && (bus.DataAdrM == BASE_ADDR + 32'd8);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push     = w_pushReq && ((r_count != FULL_COUNT) || w_pop);
    assign w_drop     = w_pushReq && !w_push;
    assign w_unused   = ^bus.WriteDataM[31:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bitCnt   <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_bitCnt <= w_bitCntNext;
            r_bitIdx <= w_bitIdxNext;
            r_shift  <= w_shiftNext;
            r_tx     <= w_txNext;
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)     r_overflow <= 1'b1;
            else if (w_clr) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wrPtr] <= bus.WriteDataM[7:0];
    end

    // The stop bit hands straight over to the next start bit when bytes are waiting.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_notEmpty) begin
                    w_nextState = START;
                    w_pop       = 1'b1;
                end
            end
            START: if (w_bitEnd) w_nextState = DATA;
            DATA:  if (w_bitEnd && (r_bitIdx == 3'd7)) w_nextState = STOP;
            STOP: begin
                if (w_bitEnd) begin
                    if (w_notEmpty) begin
                        w_nextState = START;
                        w_pop       = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_bitCntNext = ((r_state == IDLE) || w_bitEnd) ? '0 : r_bitCnt + CNT_W'(1);
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        if (w_pop) begin
            w_shiftNext = r_fifo[r_rdPtr];
        end else if ((r_state == DATA) && w_bitEnd) begin
            w_shiftNext  = r_shift >> 1;
            w_bitIdxNext = r_bitIdx + 3'd1;
        end
        case (w_nextState)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            default: w_txNext = 1'b1;
        endcase
    end

    assign tx        = r_tx;
    assign busy      = (r_state != IDLE);
    assign fifo_full = (r_count == FULL_COUNT);
    assign w_status  = {r_overflow, !w_notEmpty, fifo_full, busy};
    assign bus.rdata = (bus.DataAdrM == BASE_ADDR + 32'd4) ? {28'b0, w_status} : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised and directed bench for mmio_uart_tx against a frame-level queue model.
module tb_mmio_uart_tx;

    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * DIV;
    localparam logic [31:0] BASE  = 32'h0000_FF00;

    logic clk = 1'b0;
    logic reset;
    logic tx, busy, fifo_full;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .tx(tx), .busy(busy), .fifo_full(fifo_full)
    );

    // Model: queue of waiting bytes plus the frame on the wire and its cycle position.
    logic [7:0] mQ[$];
    logic [7:0] mFrame;
    int         mPos = -1;
    bit         mOverflow = 1'b0;

    task automatic modelStep(input logic we, input logic [31:0] addr, input logic [7:0] data);
        int  sizeBefore;
        bit  popNow;
        if (reset) begin
            mQ.delete();
            mPos = -1;
            mOverflow = 1'b0;
            return;
        end
        sizeBefore = mQ.size();
        popNow = (sizeBefore > 0) && ((mPos < 0) || (mPos == FRAME - 1));
        if (popNow) begin
            mFrame = mQ.pop_front();
            mPos = 0;
        end else if (mPos == FRAME - 1) begin
            mPos = -1;
        end else if (mPos >= 0) begin
            mPos++;
        end
        if (we && addr == BASE) begin
            if (sizeBefore < DEPTH || popNow) mQ.push_back(data);
            else mOverflow = 1'b1;
        end else if (we && addr == BASE + 32'd8) begin
            mOverflow = 1'b0;
        end
    endtask

    function automatic logic expTx();
        int b;
        if (mPos < 0) return 1'b1;
        b = mPos / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return mFrame[b-1];
    endfunction

    function automatic logic expBusy();
        return mPos >= 0;
    endfunction

    function automatic logic [31:0] expRdata(input logic [31:0] addr);
        if (addr != BASE + 32'd4) return 32'h0;
        return {28'b0, mOverflow, mQ.size() == 0, mQ.size() == DEPTH, mPos >= 0};
    endfunction

    task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.MemWriteM  = we;
        bus.DataAdrM   = addr;
        bus.WriteDataM = data;
        modelStep(we, addr, data[7:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle(1'b1, BASE, $urandom);
        testsRun++;
        if (tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_tx got %b want 1", tx); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        testsRun++;
        if (fifo_full !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_full got %b want 0", fifo_full); end
        cycle(1'b0, BASE + 32'd4, 32'h0);
        testsRun++;
        if (bus.rdata !== 32'h4) begin testsFailed++; $display("[TB] FAIL reset_status got %h want 4", bus.rdata); end
        reset = 1'b0;
        cycle(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_single_frame();
        logic [7:0] val = 8'h55;
        logic       lit;
        int         busyFall = -1;
        cycle(1'b1, BASE, {24'h0, val});
        for (int k = 1; k <= 44; k++) begin
            cycle(1'b0, 32'h0, 32'h0);
            lit = (k <= 4) ? 1'b0 : (k <= 36) ? val[(k - 5) / 4] : 1'b1;
            testsRun++;
            if (tx !== lit) begin testsFailed++; $display("[TB] FAIL frame55_tx k=%0d got %b want %b", k, tx, lit); end
            testsRun++;
            if (tx !== expTx()) begin testsFailed++; $display("[TB] FAIL frame55_model_tx k=%0d got %b want %b", k, tx, expTx()); end
            testsRun++;
            if (busy !== expBusy()) begin testsFailed++; $display("[TB] FAIL frame55_busy k=%0d got %b want %b", k, busy, expBusy()); end
            if (busy === 1'b0 && busyFall < 0) busyFall = k;
        end
        testsRun++;
        if (busyFall != 41) begin testsFailed++; $display("[TB] FAIL frame55_busy_fall got %0d want 41", busyFall); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'hA5, 8'h3C, 8'hFF};
        logic       samp [0:130];
        logic [7:0] got;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, BASE, {24'h0, bytes[i]});
            samp[i] = tx;
        end
        for (int k = 3; k <= 130; k++) begin
            cycle(1'b0, 32'h0, 32'h0);
            samp[k] = tx;
            testsRun++;
            if (tx !== expTx()) begin testsFailed++; $display("[TB] FAIL b2b_tx k=%0d got %b want %b", k, tx, expTx()); end
        end
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 8; b++) got[b] = samp[1 + 40*f + 4*(b+1) + 2];
            testsRun++;
            if (samp[1 + 40*f] !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_start f=%0d got %b want 0", f, samp[1 + 40*f]); end
            testsRun++;
            if (got !== bytes[f]) begin testsFailed++; $display("[TB] FAIL b2b_byte f=%0d got %h want %h", f, got, bytes[f]); end
            testsRun++;
            if (samp[1 + 40*f + 38] !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_stop f=%0d got %b want 1", f, samp[1 + 40*f + 38]); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, BASE, $urandom);
            if (i == 4) begin
                testsRun++;
                if (fifo_full !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_full_on_5th got %b want 1", fifo_full); end
            end
        end
        cycle(1'b0, BASE + 32'd4, 32'h0);
        testsRun++;
        if (bus.rdata !== 32'hB) begin testsFailed++; $display("[TB] FAIL ovf_status got %h want b", bus.rdata); end
        for (int k = 7; k <= 210; k++) begin
            cycle(1'b0, 32'h0, 32'h0);
            testsRun++;
            if (tx !== expTx()) begin testsFailed++; $display("[TB] FAIL ovf_tx k=%0d got %b want %b", k, tx, expTx()); end
            if (k == 200 || k == 201) begin
                testsRun++;
                if (busy !== (k == 200)) begin testsFailed++; $display("[TB] FAIL ovf_busy_end k=%0d got %b want %b", k, busy, k == 200); end
            end
        end
        cycle(1'b1, BASE + 32'd8, 32'h0);
        cycle(1'b0, BASE + 32'd4, 32'h0);
        testsRun++;
        if (bus.rdata !== 32'h4) begin testsFailed++; $display("[TB] FAIL ovf_clear got %h want 4", bus.rdata); end
    endtask

    task automatic test_status();
        cycle(1'b0, BASE + 32'd4, 32'h0);
        testsRun++;
        if (bus.rdata !== 32'h4) begin testsFailed++; $display("[TB] FAIL status_idle got %h want 4", bus.rdata); end
        cycle(1'b1, BASE, $urandom);
        cycle(1'b0, 32'h0, 32'h0);
        cycle(1'b1, BASE, $urandom);
        cycle(1'b0, BASE + 32'd4, 32'h0);
        testsRun++;
        if (bus.rdata !== 32'h1) begin testsFailed++; $display("[TB] FAIL status_midframe got %h want 1", bus.rdata); end
        testsRun++;
        if (bus.rdata !== expRdata(bus.DataAdrM)) begin testsFailed++; $display("[TB] FAIL status_model got %h want %h", bus.rdata, expRdata(bus.DataAdrM)); end
        cycle(1'b0, 32'h64, 32'h0);
        testsRun++;
        if (bus.rdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL status_other_addr got %h want 0", bus.rdata); end
        for (int k = 0; k < 90; k++) begin
            cycle(1'b0, 32'h0, 32'h0);
            testsRun++;
            if (tx !== expTx()) begin testsFailed++; $display("[TB] FAIL status_drain_tx k=%0d got %b want %b", k, tx, expTx()); end
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 3; i++) cycle(1'b1, BASE, $urandom);
        repeat (8) cycle(1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        cycle(1'b0, BASE + 32'd4, 32'h0);
        testsRun++;
        if (tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_tx got %b want 1", tx); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        testsRun++;
        if (bus.rdata !== 32'h4) begin testsFailed++; $display("[TB] FAIL rstmid_status got %h want 4", bus.rdata); end
        reset = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cycle(1'b0, 32'h0, 32'h0);
            testsRun++;
            if (tx !== 1'b1 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_quiet k=%0d got tx=%b busy=%b want tx=1 busy=0", k, tx, busy); end
        end
    endtask

    task automatic test_ignored_stores();
        cycle(1'b1, 32'h64, $urandom);
        cycle(1'b1, BASE + 32'd4, $urandom);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 32'h0, 32'h0);
            testsRun++;
            if (tx !== 1'b1 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ignored_quiet k=%0d got tx=%b busy=%b want tx=1 busy=0", k, tx, busy); end
        end
        cycle(1'b0, BASE + 32'd4, 32'h0);
        testsRun++;
        if (bus.rdata !== 32'h4) begin testsFailed++; $display("[TB] FAIL ignored_status got %h want 4", bus.rdata); end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] addr;
        int          sel;
        for (int k = 0; k < 1100; k++) begin
            sel = $urandom_range(0, 9);
            addr = (sel <= 5) ? BASE : (sel == 6) ? BASE + 32'd8 : (sel == 7) ? BASE + 32'd4 :
                   (sel == 8) ? 32'h64 : BASE + 32'd12;
            we = (k < 800) && ($urandom_range(0, 99) < ((k < 400) ? 30 : 4));
            cycle(we, addr, $urandom);
            testsRun++;
            if (tx !== expTx() || busy !== expBusy() || fifo_full !== (mQ.size() == DEPTH) ||
                bus.rdata !== expRdata(addr)) begin
                testsFailed++;
                $display("[TB] FAIL random k=%0d got tx=%b busy=%b full=%b rdata=%h want tx=%b busy=%b full=%b rdata=%h",
                         k, tx, busy, fifo_full, bus.rdata, expTx(), expBusy(), mQ.size() == DEPTH, expRdata(addr));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.MemWriteM = 1'b0;
        bus.DataAdrM = 32'h0;
        bus.WriteDataM = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_status();
        test_reset_midframe();
        test_ignored_stores();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
